// File: rtl/sd_seq_monitor_if.sv
// Sequence-monitor bus: upstream handshake, back-pressure pattern, clear and status outputs.
interface sd_seq_monitor_if #(
    parameter int width     = 10,
    parameter int cnt_width = 16
);
    logic                 c_srdy;
    logic                 c_drdy;
    logic [width-1:0]     c_data;
    logic [7:0]           drdy_pat;
    logic                 clr;
    logic [cnt_width-1:0] ok_cnt;
    logic [cnt_width-1:0] err_cnt;
    logic                 err_sticky;
    logic [width-1:0]     err_exp;
    logic [width-1:0]     err_got;

    modport master (
        output c_srdy, c_data, drdy_pat, clr,
        input  c_drdy, ok_cnt, err_cnt, err_sticky, err_exp, err_got
    );

    modport slave (
        input  c_srdy, c_data, drdy_pat, clr,
        output c_drdy, ok_cnt, err_cnt, err_sticky, err_exp, err_got
    );
endinterface

// File: rtl/sd_seq_monitor.sv
// Incrementing-sequence checker: applies a rotating back-pressure pattern, syncs on the
// first accepted beat, then counts matching and mismatching beats (saturating).
module sd_seq_monitor #(
    parameter int width     = 10,
    parameter int cnt_width = 16
) (
    input  logic           clk,
    input  logic           reset,
    sd_seq_monitor_if.slave mon
);
    typedef enum logic {SYNC, RUN} state_t;

    state_t               state_q;
    logic [2:0]           pat_idx_q;
    logic                 c_drdy_q;
    logic [width-1:0]     exp_q;
    logic [cnt_width-1:0] ok_cnt_q;
    logic [cnt_width-1:0] err_cnt_q;
    logic                 err_sticky_q;
    logic [width-1:0]     err_exp_q;
    logic [width-1:0]     err_got_q;

    logic                 xfer;
    logic [width-1:0]     data_inc;

    assign xfer     = mon.c_srdy && c_drdy_q;
    assign data_inc = mon.c_data + width'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= SYNC;
            pat_idx_q    <= '0;
            c_drdy_q     <= 1'b0;
            exp_q        <= '0;
            ok_cnt_q     <= '0;
            err_cnt_q    <= '0;
            err_sticky_q <= 1'b0;
            err_exp_q    <= '0;
            err_got_q    <= '0;
        end else begin
            // Back-pressure keeps rotating regardless of clear or traffic
            pat_idx_q <= pat_idx_q + 3'd1;
            c_drdy_q  <= mon.drdy_pat[pat_idx_q];
            if (mon.clr) begin
                state_q      <= SYNC;
                ok_cnt_q     <= '0;
                err_cnt_q    <= '0;
                err_sticky_q <= 1'b0;
                err_exp_q    <= '0;
                err_got_q    <= '0;
            end else if (xfer) begin
                exp_q <= data_inc;
                case (state_q)
                    SYNC: state_q <= RUN;
                    RUN: begin
                        if (mon.c_data == exp_q) begin
                            if (ok_cnt_q != '1) ok_cnt_q <= ok_cnt_q + cnt_width'(1);
                        end else begin
                            if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + cnt_width'(1);
                            err_sticky_q <= 1'b1;
                            err_exp_q    <= exp_q;
                            err_got_q    <= mon.c_data;
                        end
                    end
                    default: state_q <= SYNC;
                endcase
            end
        end
    end

    assign mon.c_drdy     = c_drdy_q;
    assign mon.ok_cnt     = ok_cnt_q;
    assign mon.err_cnt    = err_cnt_q;
    assign mon.err_sticky = err_sticky_q;
    assign mon.err_exp    = err_exp_q;
    assign mon.err_got    = err_got_q;
endmodule

// File: tb/tb_sd_seq_monitor.sv
// Directed bench for sd_seq_monitor; inputs change on falling edges, outputs sampled there.
module tb_sd_seq_monitor;
    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    sd_seq_monitor_if #(.width(10), .cnt_width(16)) bus ();
    sd_seq_monitor_if #(.width(10), .cnt_width(3))  bus2 ();

    sd_seq_monitor #(.width(10), .cnt_width(16)) dut  (.clk(clk), .reset(reset), .mon(bus.slave));
    sd_seq_monitor #(.width(10), .cnt_width(3))  dut2 (.clk(clk), .reset(reset), .mon(bus2.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Offer one beat and wait until it is accepted; entered and left on a falling edge.
    task automatic send(input logic [9:0] v);
        bit done = 1'b0;
        bus.c_srdy = 1'b1;
        bus.c_data = v;
        for (int i = 0; i < 20 && !done; i++) begin
            if (bus.c_drdy === 1'b1) done = 1'b1;
            @(negedge clk);
        end
        if (!done) begin
            fails++;
            $error("FAIL send_timeout got=no_accept exp=accept value=%0d", v);
        end
        bus.c_srdy = 1'b0;
    endtask

    task automatic pulse_clr();
        bus.clr = 1'b1;
        @(negedge clk);
        bus.clr = 1'b0;
    endtask

    initial begin
        logic [7:0] pat;
        bit prev;

        reset = 1'b0;
        bus.c_srdy = 1'b0;  bus.c_data = '0;  bus.drdy_pat = 8'hFF;  bus.clr = 1'b0;
        bus2.c_srdy = 1'b0; bus2.c_data = '0; bus2.drdy_pat = 8'hFF; bus2.clr = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_drdy", bus.c_drdy, 0);
        check("rst_ok", bus.ok_cnt, 0);
        check("rst_err", bus.err_cnt, 0);
        check("rst_sticky", bus.err_sticky, 0);
        check("rst_exp", bus.err_exp, 0);
        check("rst_got", bus.err_got, 0);
        reset = 1'b1;

        // Continuous 0..99
        for (int v = 0; v < 100; v++) send(10'(v));
        check("seq_ok", bus.ok_cnt, 99);
        check("seq_err", bus.err_cnt, 0);
        check("seq_sticky", bus.err_sticky, 0);

        // Wrap-around 1020..1023,0..3
        pulse_clr();
        check("clr_ok", bus.ok_cnt, 0);
        for (int v = 1020; v < 1028; v++) send(10'(v % 1024));
        check("wrap_ok", bus.ok_cnt, 7);
        check("wrap_err", bus.err_cnt, 0);

        // Mismatch 5,6,9,10
        pulse_clr();
        send(10'd5); send(10'd6); send(10'd9); send(10'd10);
        check("mis_ok", bus.ok_cnt, 2);
        check("mis_err", bus.err_cnt, 1);
        check("mis_exp", bus.err_exp, 7);
        check("mis_got", bus.err_got, 9);
        check("mis_sticky", bus.err_sticky, 1);

        // Pattern 00: data offered but never accepted
        bus.drdy_pat = 8'h00;
        repeat (2) @(negedge clk);
        bus.c_srdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.c_data = 10'(77 + i);
            @(negedge clk);
        end
        check("hold_drdy", bus.c_drdy, 0);
        check("hold_ok", bus.ok_cnt, 2);
        check("hold_err", bus.err_cnt, 1);
        check("hold_got", bus.err_got, 9);
        bus.c_srdy = 1'b0;
        bus.drdy_pat = 8'hFF;

        // Clear coincident with beat 50
        bus.clr = 1'b1;
        send(10'd50);
        bus.clr = 1'b0;
        check("clr_ok0", bus.ok_cnt, 0);
        check("clr_err0", bus.err_cnt, 0);
        check("clr_sticky0", bus.err_sticky, 0);
        check("clr_exp0", bus.err_exp, 0);
        check("clr_got0", bus.err_got, 0);
        send(10'd51); send(10'd52);
        check("clr_ok1", bus.ok_cnt, 1);
        check("clr_err1", bus.err_cnt, 0);

        // Mid-stream reset at 200, resume at 300
        for (int v = 195; v < 200; v++) send(10'(v));
        check("pre_rst_err", bus.err_cnt, 1);
        reset = 1'b0;
        bus.c_srdy = 1'b1;
        bus.c_data = 10'd200;
        @(negedge clk);
        reset = 1'b1;
        bus.c_srdy = 1'b0;
        check("mrst_drdy", bus.c_drdy, 0);
        check("mrst_ok", bus.ok_cnt, 0);
        check("mrst_err", bus.err_cnt, 0);
        check("mrst_sticky", bus.err_sticky, 0);
        check("mrst_exp", bus.err_exp, 0);
        check("mrst_got", bus.err_got, 0);
        send(10'd300); send(10'd301);
        check("mrst_ok1", bus.ok_cnt, 1);
        check("mrst_err1", bus.err_cnt, 0);

        // Pattern A5 from a clean reset with c_srdy held high
        pat = 8'hA5;
        bus.drdy_pat = pat;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("a5_first", bus.c_drdy, 0);
        bus.c_data = 10'd500;
        bus.c_srdy = 1'b1;
        prev = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            if (prev) bus.c_data = bus.c_data + 10'd1;
            check($sformatf("a5_drdy%0d", k), bus.c_drdy, pat[(k - 1) % 8]);
            prev = pat[(k - 1) % 8];
        end
        @(negedge clk);
        bus.c_srdy = 1'b0;
        check("a5_ok", bus.ok_cnt, 7);
        check("a5_err", bus.err_cnt, 0);

        // Saturation on the 3-bit-counter instance
        bus2.c_srdy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus2.c_data = 10'(i);
            @(negedge clk);
        end
        check("sat_ok", bus2.ok_cnt, 7);
        bus2.c_data = 10'd0;
        repeat (10) @(negedge clk);
        bus2.c_srdy = 1'b0;
        check("sat_err", bus2.err_cnt, 7);
        check("sat_ok_hold", bus2.ok_cnt, 7);
        check("sat_sticky", bus2.err_sticky, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
